// File: rtl/dispatcher_if.sv
// Shared widths and opcode classes for the issue stage, plus the bundle of
// signals between the dispatcher and its neighbours (IQ, RF, ROB, RS, LSB, CDBs).
package dispatcher_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int ROB_WIDTH  = 4;
    localparam int ROB_SIZE   = 16;
    localparam int OP_WIDTH   = 6;
    localparam int REG_WIDTH  = 5;

    // ALU class opcodes
    localparam logic [OP_WIDTH-1:0] OP_ADD  = 6'd1;
    localparam logic [OP_WIDTH-1:0] OP_ADDI = 6'd2;
    // Load/store class occupies one contiguous range, LB..SW
    localparam logic [OP_WIDTH-1:0] OP_LB   = 6'd20;
    localparam logic [OP_WIDTH-1:0] OP_LW   = 6'd22;
    localparam logic [OP_WIDTH-1:0] OP_SW   = 6'd27;

    typedef struct packed {
        logic [ROB_WIDTH-1:0]  q;
        logic [DATA_WIDTH-1:0] v;
    } operand_t;

    function automatic logic is_ls_op(input logic [OP_WIDTH-1:0] op);
        return (op >= OP_LB) && (op <= OP_SW);
    endfunction
endpackage

interface dispatcher_if;
    import dispatcher_pkg::*;

    logic                  rdy_in;
    // instruction queue head
    logic                  rdy_iq_in;
    logic [OP_WIDTH-1:0]   opcode_iq_in;
    logic [ADDR_WIDTH-1:0] pc_iq_in;
    logic [DATA_WIDTH-1:0] imm_iq_in;
    logic [REG_WIDTH-1:0]  rd_iq_in;
    logic [REG_WIDTH-1:0]  rs1_iq_in;
    logic [REG_WIDTH-1:0]  rs2_iq_in;
    logic                  use_rs1_iq_in;
    logic                  use_rs2_iq_in;
    logic                  pred_jump_iq_in;
    logic                  pop_iq_out;
    // register file lookup
    logic [REG_WIDTH-1:0]  rs1_rf_out;
    logic [REG_WIDTH-1:0]  rs2_rf_out;
    logic [ROB_WIDTH-1:0]  q1_rf_in;
    logic [ROB_WIDTH-1:0]  q2_rf_in;
    logic [DATA_WIDTH-1:0] v1_rf_in;
    logic [DATA_WIDTH-1:0] v2_rf_in;
    // ROB lookup and capacity
    logic                  rob_rdy1_in;
    logic [DATA_WIDTH-1:0] rob_val1_in;
    logic                  rob_rdy2_in;
    logic [DATA_WIDTH-1:0] rob_val2_in;
    logic                  rob_full_in;
    logic                  rs_full_rs_in;
    logic                  lsb_full_lsb_in;
    logic [ROB_WIDTH-1:0]  rob_free_id_in;
    // common data buses
    logic                  rdy_a_cdb_in;
    logic [DATA_WIDTH-1:0] result_a_cdb_in;
    logic [ROB_WIDTH-1:0]  rob_id_a_cdb_in;
    logic                  rdy_ls_cdb_in;
    logic [DATA_WIDTH-1:0] result_ls_cdb_in;
    logic [ROB_WIDTH-1:0]  rob_id_ls_cdb_in;
    logic                  refresh_rob_cdb_in;
    // issue strobes and shared payload
    logic                  rdy_rs_out;
    logic                  rdy_lsb_out;
    logic                  rdy_rob_out;
    logic                  rdy_rf_out;
    logic [OP_WIDTH-1:0]   opcode_out;
    logic [ADDR_WIDTH-1:0] pc_out;
    logic [DATA_WIDTH-1:0] imm_out;
    logic [REG_WIDTH-1:0]  rd_out;
    logic                  pred_jump_out;
    logic [ROB_WIDTH-1:0]  qj_out;
    logic [ROB_WIDTH-1:0]  qk_out;
    logic [ROB_WIDTH-1:0]  rob_id_out;
    logic [DATA_WIDTH-1:0] vj_out;
    logic [DATA_WIDTH-1:0] vk_out;

    // Dispatcher side
    modport master (
        input  rdy_in, rdy_iq_in, opcode_iq_in, pc_iq_in, imm_iq_in,
               rd_iq_in, rs1_iq_in, rs2_iq_in, use_rs1_iq_in, use_rs2_iq_in,
               pred_jump_iq_in, q1_rf_in, q2_rf_in, v1_rf_in, v2_rf_in,
               rob_rdy1_in, rob_val1_in, rob_rdy2_in, rob_val2_in,
               rob_full_in, rs_full_rs_in, lsb_full_lsb_in, rob_free_id_in,
               rdy_a_cdb_in, result_a_cdb_in, rob_id_a_cdb_in,
               rdy_ls_cdb_in, result_ls_cdb_in, rob_id_ls_cdb_in,
               refresh_rob_cdb_in,
        output pop_iq_out, rs1_rf_out, rs2_rf_out,
               rdy_rs_out, rdy_lsb_out, rdy_rob_out, rdy_rf_out,
               opcode_out, pc_out, imm_out, rd_out, pred_jump_out,
               qj_out, qk_out, rob_id_out, vj_out, vk_out
    );

    // Surrounding pipeline side
    modport slave (
        output rdy_in, rdy_iq_in, opcode_iq_in, pc_iq_in, imm_iq_in,
               rd_iq_in, rs1_iq_in, rs2_iq_in, use_rs1_iq_in, use_rs2_iq_in,
               pred_jump_iq_in, q1_rf_in, q2_rf_in, v1_rf_in, v2_rf_in,
               rob_rdy1_in, rob_val1_in, rob_rdy2_in, rob_val2_in,
               rob_full_in, rs_full_rs_in, lsb_full_lsb_in, rob_free_id_in,
               rdy_a_cdb_in, result_a_cdb_in, rob_id_a_cdb_in,
               rdy_ls_cdb_in, result_ls_cdb_in, rob_id_ls_cdb_in,
               refresh_rob_cdb_in,
        input  pop_iq_out, rs1_rf_out, rs2_rf_out,
               rdy_rs_out, rdy_lsb_out, rdy_rob_out, rdy_rf_out,
               opcode_out, pc_out, imm_out, rd_out, pred_jump_out,
               qj_out, qk_out, rob_id_out, vj_out, vk_out
    );
endinterface

// File: rtl/dispatcher.sv
// Issue stage: pops one decoded instruction per cycle, allocates a ROB id,
// renames both source operands and emits a one-cycle registered issue pulse.
module dispatcher
    import dispatcher_pkg::*;
(
    input logic      clk_in,
    input logic      rst_in,
    dispatcher_if.master bus
);

    logic                  is_ls_s;
    logic                  slot_free_s;
    logic                  issue_s;
    logic [ROB_WIDTH-1:0]  next_id_s;
    logic [ROB_WIDTH-1:0]  alloc_id_s;
    operand_t              opj_s;
    operand_t              opk_s;

    logic                  rdy_rs_r;
    logic                  rdy_lsb_r;
    logic                  rdy_rob_r;
    logic                  rdy_rf_r;
    logic [OP_WIDTH-1:0]   opcode_r;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic [DATA_WIDTH-1:0] imm_r;
    logic [REG_WIDTH-1:0]  rd_r;
    logic                  pred_jump_r;
    logic [ROB_WIDTH-1:0]  qj_r;
    logic [ROB_WIDTH-1:0]  qk_r;
    logic [ROB_WIDTH-1:0]  rob_id_r;
    logic [DATA_WIDTH-1:0] vj_r;
    logic [DATA_WIDTH-1:0] vk_r;

    // Operand rename with priority: unused, in-flight forward, RF value,
    // ROB value, ALU CDB, LS CDB, otherwise wait on the RF tag.
    function automatic operand_t resolve(
        input logic                  use_src,
        input logic [REG_WIDTH-1:0]  idx,
        input logic                  fwd_valid,
        input logic [REG_WIDTH-1:0]  fwd_rd,
        input logic [ROB_WIDTH-1:0]  fwd_id,
        input logic [ROB_WIDTH-1:0]  q_rf,
        input logic [DATA_WIDTH-1:0] v_rf,
        input logic                  rob_rdy,
        input logic [DATA_WIDTH-1:0] rob_val,
        input logic                  a_rdy,
        input logic [ROB_WIDTH-1:0]  a_id,
        input logic [DATA_WIDTH-1:0] a_res,
        input logic                  ls_rdy,
        input logic [ROB_WIDTH-1:0]  ls_id,
        input logic [DATA_WIDTH-1:0] ls_res
    );
        operand_t r;
        r.q = ROB_WIDTH'(1'b0);
        r.v = DATA_WIDTH'(1'b0);
        if (!use_src || idx == 5'd0) begin
            r.q = ROB_WIDTH'(1'b0);
        end else if (fwd_valid && fwd_rd == idx) begin
            r.q = fwd_id;
        end else if (q_rf == ROB_WIDTH'(1'b0)) begin
            r.v = v_rf;
        end else if (rob_rdy) begin
            r.v = rob_val;
        end else if (a_rdy && a_id == q_rf) begin
            r.v = a_res;
        end else if (ls_rdy && ls_id == q_rf) begin
            r.v = ls_res;
        end else begin
            r.q = q_rf;
        end
        return r;
    endfunction

    // Issue decision, ROB id allocation and operand rename for this cycle
    always_comb begin
        is_ls_s = is_ls_op(bus.opcode_iq_in);
        if (is_ls_s) begin
            slot_free_s = !bus.lsb_full_lsb_in;
        end else begin
            slot_free_s = !bus.rs_full_rs_in;
        end
        issue_s = !rst_in && bus.rdy_in && bus.rdy_iq_in && !bus.refresh_rob_cdb_in
                  && !bus.rob_full_in && slot_free_s;

        if (rob_id_r == ROB_WIDTH'(ROB_SIZE - 1)) begin
            next_id_s = ROB_WIDTH'(1'b1);
        end else begin
            next_id_s = rob_id_r + ROB_WIDTH'(1'b1);
        end
        // The ROB tail has not yet advanced for the previous issue
        if (rdy_rob_r) begin
            alloc_id_s = next_id_s;
        end else begin
            alloc_id_s = bus.rob_free_id_in;
        end

        opj_s = resolve(bus.use_rs1_iq_in, bus.rs1_iq_in, rdy_rf_r, rd_r, rob_id_r,
                        bus.q1_rf_in, bus.v1_rf_in, bus.rob_rdy1_in, bus.rob_val1_in,
                        bus.rdy_a_cdb_in, bus.rob_id_a_cdb_in, bus.result_a_cdb_in,
                        bus.rdy_ls_cdb_in, bus.rob_id_ls_cdb_in, bus.result_ls_cdb_in);
        opk_s = resolve(bus.use_rs2_iq_in, bus.rs2_iq_in, rdy_rf_r, rd_r, rob_id_r,
                        bus.q2_rf_in, bus.v2_rf_in, bus.rob_rdy2_in, bus.rob_val2_in,
                        bus.rdy_a_cdb_in, bus.rob_id_a_cdb_in, bus.result_a_cdb_in,
                        bus.rdy_ls_cdb_in, bus.rob_id_ls_cdb_in, bus.result_ls_cdb_in);
    end

    // Issue register: strobes pulse per instruction, payload holds otherwise
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rdy_rs_r    <= 1'b0;
            rdy_lsb_r   <= 1'b0;
            rdy_rob_r   <= 1'b0;
            rdy_rf_r    <= 1'b0;
            opcode_r    <= OP_WIDTH'(1'b0);
            pc_r        <= ADDR_WIDTH'(1'b0);
            imm_r       <= DATA_WIDTH'(1'b0);
            rd_r        <= 5'd0;
            pred_jump_r <= 1'b0;
            qj_r        <= ROB_WIDTH'(1'b0);
            qk_r        <= ROB_WIDTH'(1'b0);
            rob_id_r    <= ROB_WIDTH'(1'b0);
            vj_r        <= DATA_WIDTH'(1'b0);
            vk_r        <= DATA_WIDTH'(1'b0);
        end else if (bus.rdy_in) begin
            if (issue_s) begin
                rdy_rs_r    <= !is_ls_s;
                rdy_lsb_r   <= is_ls_s;
                rdy_rob_r   <= 1'b1;
                rdy_rf_r    <= (bus.rd_iq_in != 5'd0);
                opcode_r    <= bus.opcode_iq_in;
                pc_r        <= bus.pc_iq_in;
                imm_r       <= bus.imm_iq_in;
                rd_r        <= bus.rd_iq_in;
                pred_jump_r <= bus.pred_jump_iq_in;
                qj_r        <= opj_s.q;
                qk_r        <= opk_s.q;
                rob_id_r    <= alloc_id_s;
                vj_r        <= opj_s.v;
                vk_r        <= opk_s.v;
            end else begin
                rdy_rs_r    <= 1'b0;
                rdy_lsb_r   <= 1'b0;
                rdy_rob_r   <= 1'b0;
                rdy_rf_r    <= 1'b0;
            end
        end
    end

    assign bus.pop_iq_out    = issue_s;
    assign bus.rs1_rf_out    = bus.rs1_iq_in;
    assign bus.rs2_rf_out    = bus.rs2_iq_in;
    assign bus.rdy_rs_out    = rdy_rs_r;
    assign bus.rdy_lsb_out   = rdy_lsb_r;
    assign bus.rdy_rob_out   = rdy_rob_r;
    assign bus.rdy_rf_out    = rdy_rf_r;
    assign bus.opcode_out    = opcode_r;
    assign bus.pc_out        = pc_r;
    assign bus.imm_out       = imm_r;
    assign bus.rd_out        = rd_r;
    assign bus.pred_jump_out = pred_jump_r;
    assign bus.qj_out        = qj_r;
    assign bus.qk_out        = qk_r;
    assign bus.rob_id_out    = rob_id_r;
    assign bus.vj_out        = vj_r;
    assign bus.vk_out        = vk_r;

endmodule

// File: tb/tb_dispatcher.sv
// Directed bench for the dispatcher: rename priorities, stalls, refresh,
// mid-stream reset, ROB id wraparound and rdy_in hold behaviour.
module tb_dispatcher;
    import dispatcher_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   consumed;

    dispatcher_if bus ();

    dispatcher dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.rdy_in             = 1'b1;
        bus.rdy_iq_in          = 1'b0;
        bus.opcode_iq_in       = 6'd0;
        bus.pc_iq_in           = 32'd0;
        bus.imm_iq_in          = 32'd0;
        bus.rd_iq_in           = 5'd0;
        bus.rs1_iq_in          = 5'd0;
        bus.rs2_iq_in          = 5'd0;
        bus.use_rs1_iq_in      = 1'b0;
        bus.use_rs2_iq_in      = 1'b0;
        bus.pred_jump_iq_in    = 1'b0;
        bus.q1_rf_in           = 4'd0;
        bus.q2_rf_in           = 4'd0;
        bus.v1_rf_in           = 32'd0;
        bus.v2_rf_in           = 32'd0;
        bus.rob_rdy1_in        = 1'b0;
        bus.rob_val1_in        = 32'd0;
        bus.rob_rdy2_in        = 1'b0;
        bus.rob_val2_in        = 32'd0;
        bus.rob_full_in        = 1'b0;
        bus.rs_full_rs_in      = 1'b0;
        bus.lsb_full_lsb_in    = 1'b0;
        bus.rob_free_id_in     = 4'd0;
        bus.rdy_a_cdb_in       = 1'b0;
        bus.result_a_cdb_in    = 32'd0;
        bus.rob_id_a_cdb_in    = 4'd0;
        bus.rdy_ls_cdb_in      = 1'b0;
        bus.result_ls_cdb_in   = 32'd0;
        bus.rob_id_ls_cdb_in   = 4'd0;
        bus.refresh_rob_cdb_in = 1'b0;
    endtask

    task automatic head(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic [31:0] imm);
        bus.rdy_iq_in     = 1'b1;
        bus.opcode_iq_in  = op;
        bus.rd_iq_in      = rd;
        bus.rs1_iq_in     = rs1;
        bus.rs2_iq_in     = rs2;
        bus.use_rs1_iq_in = u1;
        bus.use_rs2_iq_in = u2;
        bus.imm_iq_in     = imm;
        bus.pc_iq_in      = 32'h1000 + {27'd0, rd} * 32'd4;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        consumed = 0;

        // reset with a valid head present
        clear_inputs();
        rst = 1'b1;
        head(OP_ADD, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 32'd0);
        #1;
        check("rst_pop", bus.pop_iq_out, 1'b0);
        tick();
        tick();
        check("rst_rdy_rs", bus.rdy_rs_out, 1'b0);
        check("rst_rdy_lsb", bus.rdy_lsb_out, 1'b0);
        check("rst_rdy_rob", bus.rdy_rob_out, 1'b0);
        check("rst_rdy_rf", bus.rdy_rf_out, 1'b0);
        check("rst_rob_id", bus.rob_id_out, 4'd0);
        check("rst_vj", bus.vj_out, 32'd0);
        rst = 1'b0;

        // ADD x3,x1,x2 with ready RF values
        clear_inputs();
        head(OP_ADD, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 32'd0);
        bus.v1_rf_in = 32'd5;
        bus.v2_rf_in = 32'd7;
        bus.rob_free_id_in = 4'd1;
        #1;
        check("add_pop", bus.pop_iq_out, 1'b1);
        check("add_rs1_rf", bus.rs1_rf_out, 5'd1);
        check("add_rs2_rf", bus.rs2_rf_out, 5'd2);
        tick();
        check("add_rdy_rs", bus.rdy_rs_out, 1'b1);
        check("add_rdy_lsb", bus.rdy_lsb_out, 1'b0);
        check("add_rdy_rob", bus.rdy_rob_out, 1'b1);
        check("add_rdy_rf", bus.rdy_rf_out, 1'b1);
        check("add_vj", bus.vj_out, 32'd5);
        check("add_vk", bus.vk_out, 32'd7);
        check("add_qj", bus.qj_out, 4'd0);
        check("add_qk", bus.qk_out, 4'd0);
        check("add_rob_id", bus.rob_id_out, 4'd1);
        check("add_rd", bus.rd_out, 5'd3);

        // ADDI x4,x3,1 back-to-back: forward from in-flight rename
        clear_inputs();
        head(OP_ADDI, 5'd4, 5'd3, 5'd0, 1'b1, 1'b0, 32'd1);
        bus.v1_rf_in = 32'd99;
        bus.rob_free_id_in = 4'd1;
        #1;
        check("fwd_pop", bus.pop_iq_out, 1'b1);
        tick();
        check("fwd_qj", bus.qj_out, 4'd1);
        check("fwd_vj", bus.vj_out, 32'd0);
        check("fwd_vk", bus.vk_out, 32'd0);
        check("fwd_rob_id", bus.rob_id_out, 4'd2);
        check("fwd_imm", bus.imm_out, 32'd1);
        check("fwd_rd", bus.rd_out, 5'd4);

        // ALU CDB capture on rs1, rs2 waits on its tag
        clear_inputs();
        head(OP_ADD, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 32'd0);
        bus.q1_rf_in = 4'd5;
        bus.rdy_a_cdb_in = 1'b1;
        bus.rob_id_a_cdb_in = 4'd5;
        bus.result_a_cdb_in = 32'h1234;
        bus.q2_rf_in = 4'd9;
        bus.v2_rf_in = 32'd3;
        tick();
        check("acdb_qj", bus.qj_out, 4'd0);
        check("acdb_vj", bus.vj_out, 32'h1234);
        check("wait_qk", bus.qk_out, 4'd9);
        check("wait_vk", bus.vk_out, 32'd0);
        check("acdb_rob_id", bus.rob_id_out, 4'd3);

        // LS CDB capture on rs1, ROB value on rs2
        clear_inputs();
        head(OP_ADD, 5'd6, 5'd6, 5'd7, 1'b1, 1'b1, 32'd0);
        bus.q1_rf_in = 4'd5;
        bus.rdy_ls_cdb_in = 1'b1;
        bus.rob_id_ls_cdb_in = 4'd5;
        bus.result_ls_cdb_in = 32'h1234;
        bus.q2_rf_in = 4'd7;
        bus.rob_rdy2_in = 1'b1;
        bus.rob_val2_in = 32'h55;
        tick();
        check("lscdb_qj", bus.qj_out, 4'd0);
        check("lscdb_vj", bus.vj_out, 32'h1234);
        check("robv_qk", bus.qk_out, 4'd0);
        check("robv_vk", bus.vk_out, 32'h55);
        check("lscdb_rob_id", bus.rob_id_out, 4'd4);

        // RS full stalls an ALU op, payload holds
        clear_inputs();
        head(OP_ADD, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 32'd0);
        bus.rs_full_rs_in = 1'b1;
        #1;
        check("rsfull_pop", bus.pop_iq_out, 1'b0);
        tick();
        check("rsfull_rdy_rs", bus.rdy_rs_out, 1'b0);
        check("rsfull_rdy_rob", bus.rdy_rob_out, 1'b0);
        check("rsfull_rob_id", bus.rob_id_out, 4'd4);

        // LW blocked by LSB full, then released
        clear_inputs();
        head(OP_LW, 5'd8, 5'd1, 5'd0, 1'b1, 1'b0, 32'd4);
        bus.v1_rf_in = 32'h40;
        bus.lsb_full_lsb_in = 1'b1;
        #1;
        check("lsbfull_pop", bus.pop_iq_out, 1'b0);
        tick();
        check("lsbfull_rdy_lsb", bus.rdy_lsb_out, 1'b0);
        check("lsbfull_rdy_rf", bus.rdy_rf_out, 1'b0);
        bus.lsb_full_lsb_in = 1'b0;
        bus.rs_full_rs_in = 1'b1;
        bus.rob_free_id_in = 4'd5;
        #1;
        check("lw_pop", bus.pop_iq_out, 1'b1);
        tick();
        check("lw_rdy_lsb", bus.rdy_lsb_out, 1'b1);
        check("lw_rdy_rs", bus.rdy_rs_out, 1'b0);
        check("lw_rob_id", bus.rob_id_out, 4'd5);
        check("lw_vj", bus.vj_out, 32'h40);
        check("lw_opcode", bus.opcode_out, OP_LW);

        // ROB full blocks issue
        clear_inputs();
        head(OP_ADD, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 32'd0);
        bus.rob_full_in = 1'b1;
        #1;
        check("robfull_pop", bus.pop_iq_out, 1'b0);
        tick();
        check("robfull_rdy_rob", bus.rdy_rob_out, 1'b0);

        // Refresh drops the issue and the rename forward
        clear_inputs();
        head(OP_ADD, 5'd3, 5'd0, 5'd0, 1'b1, 1'b1, 32'd0);
        bus.rob_free_id_in = 4'd6;
        tick();
        check("pre_ref_rob_id", bus.rob_id_out, 4'd6);
        clear_inputs();
        head(OP_ADDI, 5'd4, 5'd3, 5'd0, 1'b1, 1'b0, 32'd1);
        bus.refresh_rob_cdb_in = 1'b1;
        #1;
        check("ref_pop", bus.pop_iq_out, 1'b0);
        tick();
        check("ref_rdy_rob", bus.rdy_rob_out, 1'b0);
        check("ref_rdy_rf", bus.rdy_rf_out, 1'b0);
        clear_inputs();
        head(OP_ADDI, 5'd4, 5'd3, 5'd0, 1'b1, 1'b0, 32'd1);
        bus.v1_rf_in = 32'h77;
        bus.rob_free_id_in = 4'd7;
        tick();
        check("postref_qj", bus.qj_out, 4'd0);
        check("postref_vj", bus.vj_out, 32'h77);
        check("postref_rob_id", bus.rob_id_out, 4'd7);

        // Reset mid-stream clears the forward
        clear_inputs();
        head(OP_ADD, 5'd3, 5'd0, 5'd0, 1'b1, 1'b1, 32'd0);
        tick();
        check("mid_rob_id", bus.rob_id_out, 4'd8);
        rst = 1'b1;
        #1;
        check("mid_rst_pop", bus.pop_iq_out, 1'b0);
        tick();
        rst = 1'b0;
        check("mid_rst_rdy_rob", bus.rdy_rob_out, 1'b0);
        check("mid_rst_rdy_rf", bus.rdy_rf_out, 1'b0);
        clear_inputs();
        head(OP_ADDI, 5'd4, 5'd3, 5'd0, 1'b1, 1'b0, 32'd1);
        bus.v1_rf_in = 32'h88;
        bus.rob_free_id_in = 4'd9;
        tick();
        check("postrst_qj", bus.qj_out, 4'd0);
        check("postrst_vj", bus.vj_out, 32'h88);
        check("postrst_rob_id", bus.rob_id_out, 4'd9);

        // ROB id wraparound on back-to-back issue
        clear_inputs();
        tick();
        check("idle_rdy_rob", bus.rdy_rob_out, 1'b0);
        head(OP_ADD, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0);
        bus.rob_free_id_in = 4'd15;
        tick();
        check("wrap_first_id", bus.rob_id_out, 4'd15);
        head(OP_ADD, 5'd11, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0);
        bus.rob_free_id_in = 4'd3;
        tick();
        check("wrap_next_id", bus.rob_id_out, 4'd1);
        check("wrap_rdy_rob", bus.rdy_rob_out, 1'b1);

        // rdy_in low for 3 cycles: pending strobe seen once
        clear_inputs();
        head(OP_ADD, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0);
        bus.rob_free_id_in = 4'd3;
        bus.rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_pop", bus.pop_iq_out, 1'b0);
            if (bus.rdy_in && bus.rdy_rob_out && bus.rob_id_out == 4'd1) consumed++;
            tick();
        end
        check("hold_rdy_rob", bus.rdy_rob_out, 1'b1);
        check("hold_rob_id", bus.rob_id_out, 4'd1);
        bus.rdy_in = 1'b1;
        #1;
        check("resume_pop", bus.pop_iq_out, 1'b1);
        if (bus.rdy_in && bus.rdy_rob_out && bus.rob_id_out == 4'd1) consumed++;
        tick();
        if (bus.rdy_in && bus.rdy_rob_out && bus.rob_id_out == 4'd1) consumed++;
        check("hold_consumed_once", consumed, 1);
        check("resume_rob_id", bus.rob_id_out, 4'd2);
        check("resume_rd", bus.rd_out, 5'd12);
        clear_inputs();
        tick();
        check("final_rdy_rs", bus.rdy_rs_out, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dispatcher.md
# dispatcher

Issue stage between the instruction queue and the out-of-order back end. Each cycle it pops at most one decoded instruction and allocates a ROB entry. It renames operands using the register file, ROB and both CDBs, then sends one registered, single-cycle issue pulse to the RS (ALU ops) or the LSB (loads/stores), plus the ROB and the register-file rename port.

## Interface
- Parameters: none. Widths come from `define.vh`: `ADDR_WIDTH`, `DATA_WIDTH`, `ROB_WIDTH`, `OP_WIDTH`, `ROB_SIZE`. Register index width is 5.
- ROB id 0 means "no dependency". Valid ids are 1..`ROB_SIZE`-1.
- Clock and reset: one clock; reset is synchronous and active-high (`clk_in`, `rst_in`).
- clk_in  in  1  clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; when low, all state holds and pop_iq_out=0
- rdy_iq_in  in  1  IQ head valid
- opcode_iq_in / pc_iq_in / imm_iq_in  in  OP/ADDR/DATA  head fields
- rd_iq_in, rs1_iq_in, rs2_iq_in  in  5 each  register indices
- use_rs1_iq_in, use_rs2_iq_in, pred_jump_iq_in  in  1 each  source-used flags; branch prediction
- pop_iq_out  out  1  combinational: head consumed this cycle
- rs1_rf_out, rs2_rf_out  out  5  combinational RF read indices
- q1_rf_in, q2_rf_in  in  ROB  rename tags
- v1_rf_in, v2_rf_in  in  DATA  register values
- rob_rdy1_in, rob_val1_in, rob_rdy2_in, rob_val2_in  in  1/DATA  ROB lookup indexed by q1_rf_in/q2_rf_in
- rob_full_in, rs_full_rs_in, lsb_full_lsb_in  in  1  full flags, each asserted with one-slot margin
- rob_free_id_in  in  ROB  ROB tail id
- rdy_a_cdb_in, result_a_cdb_in, rob_id_a_cdb_in  in  1/DATA/ROB  ALU CDB
- rdy_ls_cdb_in, result_ls_cdb_in, rob_id_ls_cdb_in  in  1/DATA/ROB  LS CDB
- refresh_rob_cdb_in  in  1  misprediction flush
- rdy_rs_out, rdy_lsb_out, rdy_rob_out, rdy_rf_out  out  1  registered issue strobes
- opcode_out, pc_out, imm_out, rd_out, pred_jump_out  out  registered shared payload
- qj_out, qk_out, rob_id_out  out  ROB  registered shared payload
- vj_out, vk_out  out  DATA  registered shared payload

## Operation
- Issue condition: issue = rdy_in & rdy_iq_in & !refresh_rob_cdb_in & !rob_full_in & (is_ls ? !lsb_full_lsb_in : !rs_full_rs_in).
  - is_ls: opcode is in the load/store class of `define.vh`.
  - pop_iq_out = issue.
- Allocated id = `rdy_rob_out` ? next(rob_id_out) : rob_free_id_in.
  - next(x) = (x == `ROB_SIZE`-1) ? 1 : x+1.
  - This covers the ROB tail update that is still in flight.
- Operand resolution runs independently for j (rs1) and k (rs2). First match wins:
  1. Source unused or index 0: q=0, v=0.
  2. rdy_rf_out & rd_out == index: q=rob_id_out, v=0. This forwards the previous issue's rename, which the RF has not written yet.
  3. q_rf == 0: q=0, v=v_rf.
  4. rob_rdy: q=0, v=rob_val.
  5. rdy_a_cdb_in & rob_id_a_cdb_in == q_rf: q=0, v=result_a_cdb_in.
  6. rdy_ls_cdb_in & rob_id_ls_cdb_in == q_rf: q=0, v=result_ls_cdb_in.
  7. Otherwise: q=q_rf, v=0.
- On issue, at the next edge:
  - payload <= resolved values.
  - rdy_rob_out <= 1.
  - rdy_rs_out <= !is_ls; rdy_lsb_out <= is_ls.
  - rdy_rf_out <= (rd != 0).
- No issue (rdy_in high): all four strobes <= 0 and payload holds.
- Refresh: no issue that cycle; all strobes <= 0 at the next edge, so the next instruction reads the RF directly.
- rdy_in low: registers hold. Consumers gate on rdy_in, so a pending strobe is consumed exactly once after rdy_in returns.

## Timing
- Reset: all strobes 0, all payload 0, pop_iq_out 0.
- Latency: decision in cycle t; strobes and payload are valid in t+1 for exactly one cycle per instruction.
- Throughput: one instruction per cycle, back-to-back allowed; strobes stay high across consecutive issues.
- Full flags are sampled in the decision cycle only. The one-slot margin absorbs the in-flight issue.
- CDB data in the decision cycle is captured here. CDB data in cycle t+1 is the consumer's responsibility.
- Reset mid-stream: the in-flight strobe is dropped and the rename forward is cleared.

## Test plan
- After reset: ADD x3,x1,x2 with q1=q2=0, v1=5, v2=7, rob_free_id=1.
  - Cycle t: pop=1.
  - t+1: rdy_rs/rob/rf=1, rdy_lsb=0, vj=5, vk=7, qj=qk=0, rob_id=1, rd=3.
- ADDI x4,x3,1 issued next cycle with rob_free_id_in still 1 and RF q1=0 -> qj=1, vj=0, rob_id=2.
- q1_rf=5, rob_rdy1=0, ALU CDB id 5 result 0x1234 in the same cycle -> qj=0, vj=0x1234. The same case via the LS CDB yields the same result.
- LW with lsb_full=1 -> pop=0 and all strobes 0. Release the flag -> rdy_lsb=1, rdy_rs=0.
- Refresh in the same cycle as a valid head -> pop=0, strobes 0 next cycle. The following ADDI x4,x3 uses the RF tag, not the stale forward.
- Back-to-back issue with rob_id_out=`ROB_SIZE`-1 -> next rob_id_out=1. Hold rdy_in low for 3 cycles between issues -> each strobe is seen exactly once.
